// File: rtl/wb_port_arbiter_pkg.sv
// Shared register-file write-port definitions and helpers for the writeback arbiter.
package wb_port_arbiter_pkg;

    localparam int REG_BUS_W  = 64;
    localparam int REG_ADDR_W = 5;

    localparam logic [REG_BUS_W-1:0]  ZERO_WORD    = '0;
    localparam logic [REG_ADDR_W-1:0] REG_X0       = '0;
    localparam logic                  REG_WENABLE  = 1'b1;
    localparam logic                  REG_WDISABLE = 1'b0;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_ALU  = 2'd1,
        GNT_LSU  = 2'd2
    } gnt_e;

    function automatic logic [31:0] rd_onehot(input logic [REG_ADDR_W-1:0] rd);
        return 32'd1 << rd;
    endfunction

endpackage

// File: rtl/wb_port_arbiter_fifo.sv
// Small per-requester result queue; exposes every slot's destination so the
// top can build the pending-write mask.
module wb_fifo
    import wb_port_arbiter_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int XLEN  = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic [REG_ADDR_W-1:0]   push_rd,
    input  logic [XLEN-1:0]         push_data,
    input  logic                    pop,
    output logic                    head_valid,
    output logic [REG_ADDR_W-1:0]   head_rd,
    output logic [XLEN-1:0]         head_data,
    output logic                    full,
    output logic [DEPTH-1:0]        ent_valid,
    output logic [DEPTH*REG_ADDR_W-1:0] ent_rd
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W:0]        count;
    logic [DEPTH-1:0]      vld;
    logic [REG_ADDR_W-1:0] rd_mem   [DEPTH];
    logic [XLEN-1:0]       data_mem [DEPTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            vld    <= '0;
        end else begin
            if (push) begin
                wr_ptr      <= wr_ptr + 1'b1;
                vld[wr_ptr] <= 1'b1;
            end
            if (pop) begin
                rd_ptr      <= rd_ptr + 1'b1;
                vld[rd_ptr] <= 1'b0;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Payload storage carries no reset; slot validity is tracked above.
    always_ff @(posedge clk) begin
        if (push) begin
            rd_mem[wr_ptr]   <= push_rd;
            data_mem[wr_ptr] <= push_data;
        end
    end

    assign head_valid = (count != '0);
    assign head_rd    = rd_mem[rd_ptr];
    assign head_data  = data_mem[rd_ptr];
    assign full       = (count == FULL_CNT);
    assign ent_valid  = vld;

    for (genvar i = 0; i < DEPTH; i++) begin : g_ent
        assign ent_rd[i*REG_ADDR_W +: REG_ADDR_W] = rd_mem[i];
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the single register-file write port between the ALU and the
// long-latency unit, and publishes which destinations still await their write.
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int DEPTH    = 2,
    parameter int MAX_WAIT = 4,
    parameter int XLEN     = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alu_valid,
    output logic                  alu_ready,
    input  logic [REG_ADDR_W-1:0] alu_rd,
    input  logic [XLEN-1:0]       alu_data,
    input  logic                  lsu_valid,
    output logic                  lsu_ready,
    input  logic [REG_ADDR_W-1:0] lsu_rd,
    input  logic [XLEN-1:0]       lsu_data,
    output logic                  wb_ena,
    output logic [REG_ADDR_W-1:0] wb_addr,
    output logic [XLEN-1:0]       wb_data,
    output logic [31:0]           pend_mask
);

    localparam logic [3:0] WAIT_MAX = MAX_WAIT[3:0];

    logic                        rdy_en;
    logic [3:0]                  wait_cnt;
    gnt_e                        gnt;

    logic                        a_push, a_pop, a_head_valid, a_full;
    logic [REG_ADDR_W-1:0]       a_head_rd;
    logic [XLEN-1:0]             a_head_data;
    logic [DEPTH-1:0]            a_ent_valid;
    logic [DEPTH*REG_ADDR_W-1:0] a_ent_rd;

    logic                        l_push, l_pop, l_head_valid, l_full;
    logic [REG_ADDR_W-1:0]       l_head_rd;
    logic [XLEN-1:0]             l_head_data;
    logic [DEPTH-1:0]            l_ent_valid;
    logic [DEPTH*REG_ADDR_W-1:0] l_ent_rd;

    // ready is held low until the first edge after reset release
    assign alu_ready = rdy_en & ~a_full;
    assign lsu_ready = rdy_en & ~l_full;

    // x0 writes complete the handshake but are dropped here
    assign a_push = alu_valid & alu_ready & (alu_rd != REG_X0);
    assign l_push = lsu_valid & lsu_ready & (lsu_rd != REG_X0);

    wb_fifo #(.DEPTH(DEPTH), .XLEN(XLEN)) u_alu_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (a_push),
        .push_rd    (alu_rd),
        .push_data  (alu_data),
        .pop        (a_pop),
        .head_valid (a_head_valid),
        .head_rd    (a_head_rd),
        .head_data  (a_head_data),
        .full       (a_full),
        .ent_valid  (a_ent_valid),
        .ent_rd     (a_ent_rd)
    );

    wb_fifo #(.DEPTH(DEPTH), .XLEN(XLEN)) u_lsu_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (l_push),
        .push_rd    (lsu_rd),
        .push_data  (lsu_data),
        .pop        (l_pop),
        .head_valid (l_head_valid),
        .head_rd    (l_head_rd),
        .head_data  (l_head_data),
        .full       (l_full),
        .ent_valid  (l_ent_valid),
        .ent_rd     (l_ent_rd)
    );

    // L wins ties unless A has already lost MAX_WAIT cycles in a row
    always_comb begin
        gnt = GNT_NONE;
        if (a_head_valid && (!l_head_valid || wait_cnt == WAIT_MAX)) begin
            gnt = GNT_ALU;
        end else if (l_head_valid) begin
            gnt = GNT_LSU;
        end
    end

    assign a_pop = (gnt == GNT_ALU);
    assign l_pop = (gnt == GNT_LSU);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdy_en   <= 1'b0;
            wait_cnt <= '0;
            wb_ena   <= REG_WDISABLE;
            wb_addr  <= REG_X0;
            wb_data  <= ZERO_WORD[XLEN-1:0];
        end else begin
            rdy_en <= 1'b1;
            if (!a_head_valid || gnt == GNT_ALU) begin
                wait_cnt <= '0;
            end else if (wait_cnt != WAIT_MAX) begin
                wait_cnt <= wait_cnt + 4'd1;
            end
            case (gnt)
                GNT_ALU: begin
                    wb_ena  <= REG_WENABLE;
                    wb_addr <= a_head_rd;
                    wb_data <= a_head_data;
                end
                GNT_LSU: begin
                    wb_ena  <= REG_WENABLE;
                    wb_addr <= l_head_rd;
                    wb_data <= l_head_data;
                end
                default: wb_ena <= REG_WDISABLE;
            endcase
        end
    end

    always_comb begin
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (a_ent_valid[i]) m = m | rd_onehot(a_ent_rd[i*REG_ADDR_W +: REG_ADDR_W]);
            if (l_ent_valid[i]) m = m | rd_onehot(l_ent_rd[i*REG_ADDR_W +: REG_ADDR_W]);
        end
        if (wb_ena) m = m | rd_onehot(wb_addr);
        pend_mask = {m[31:1], 1'b0};
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter against a queue-based reference model.
module tb_wb_port_arbiter;

    localparam int DEPTH    = 2;
    localparam int MAX_WAIT = 4;
    localparam int XLEN     = 64;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            alu_valid = 1'b0, lsu_valid = 1'b0;
    logic            alu_ready, lsu_ready;
    logic [4:0]      alu_rd = '0, lsu_rd = '0;
    logic [XLEN-1:0] alu_data = '0, lsu_data = '0;
    logic            wb_ena;
    logic [4:0]      wb_addr;
    logic [XLEN-1:0] wb_data;
    logic [31:0]     pend_mask;

    always #5 clk = ~clk;

    wb_port_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT), .XLEN(XLEN)) dut (
        .clk       (clk),
        .rst       (rst),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .lsu_valid (lsu_valid),
        .lsu_ready (lsu_ready),
        .lsu_rd    (lsu_rd),
        .lsu_data  (lsu_data),
        .wb_ena    (wb_ena),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .pend_mask (pend_mask)
    );

    typedef struct packed {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } wr_t;

    wr_t        mq_a[$];
    wr_t        mq_l[$];
    wr_t        exp_q[$];
    int         mwait;
    bit         m_rdy;
    bit         m_wb_ena;
    logic [4:0] m_wb_rd;
    int         tests = 0;
    int         fails = 0;
    bit         src_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_pend();
        logic [31:0] m;
        m = '0;
        foreach (mq_a[i]) m[mq_a[i].rd] = 1'b1;
        foreach (mq_l[i]) m[mq_l[i].rd] = 1'b1;
        if (m_wb_ena) m[m_wb_rd] = 1'b1;
        return m;
    endfunction

    // Compare DUT state against the model as it stands after the last edge.
    task automatic model_check();
        chk("alu_ready", 64'(alu_ready), 64'(m_rdy && mq_a.size() < DEPTH));
        chk("lsu_ready", 64'(lsu_ready), 64'(m_rdy && mq_l.size() < DEPTH));
        chk("wb_ena", 64'(wb_ena), 64'(m_wb_ena));
        if (m_wb_ena) chk("wb_addr_now", 64'(wb_addr), 64'(m_wb_rd));
        chk("pend_mask", 64'(pend_mask), 64'(model_pend()));
    endtask

    // Advance the model across the coming edge using the inputs just applied.
    task automatic model_step();
        bit  ta, tl, a_ne, ga, gl;
        wr_t e;
        ta   = alu_valid && m_rdy && (mq_a.size() < DEPTH);
        tl   = lsu_valid && m_rdy && (mq_l.size() < DEPTH);
        a_ne = mq_a.size() > 0;
        ga   = a_ne && (mq_l.size() == 0 || mwait == MAX_WAIT);
        gl   = (mq_l.size() > 0) && !ga;
        if (!a_ne || ga) mwait = 0;
        else if (mwait < MAX_WAIT) mwait++;
        m_wb_ena = ga || gl;
        if (ga) e = mq_a.pop_front();
        else if (gl) e = mq_l.pop_front();
        if (m_wb_ena) begin
            m_wb_rd = e.rd;
            exp_q.push_back(e);
        end
        if (ta && alu_rd != 5'd0) mq_a.push_back(wr_t'{rd: alu_rd, data: alu_data});
        if (tl && lsu_rd != 5'd0) mq_l.push_back(wr_t'{rd: lsu_rd, data: lsu_data});
        m_rdy = 1'b1;
    endtask

    task automatic cyc(input bit av, input logic [4:0] ard, input logic [XLEN-1:0] ad,
                       input bit lv, input logic [4:0] lrd, input logic [XLEN-1:0] ld);
        @(negedge clk);
        model_check();
        alu_valid = av; alu_rd = ard; alu_data = ad;
        lsu_valid = lv; lsu_rd = lrd; lsu_data = ld;
        model_step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 5'd0, '0, 0, 5'd0, '0);
    endtask

    task automatic do_reset();
        #2 rst = 1'b0;
        alu_valid = 1'b0;
        lsu_valid = 1'b0;
        mq_a.delete(); mq_l.delete(); exp_q.delete();
        mwait = 0; m_rdy = 1'b0; m_wb_ena = 1'b0; m_wb_rd = '0;
        #1;
        chk("rst_wb_ena", 64'(wb_ena), 64'd0);
        chk("rst_wb_addr", 64'(wb_addr), 64'd0);
        chk("rst_wb_data", 64'(wb_data), 64'd0);
        chk("rst_pend", 64'(pend_mask), 64'd0);
        chk("rst_alu_ready", 64'(alu_ready), 64'd0);
        chk("rst_lsu_ready", 64'(lsu_ready), 64'd0);
        repeat (2) @(negedge clk);
        chk("rst_hold_wb_ena", 64'(wb_ena), 64'd0);
        chk("rst_hold_ready", 64'({alu_ready, lsu_ready}), 64'd0);
        rst = 1'b1;
        #1;
        chk("rel_alu_ready", 64'(alu_ready), 64'd0);
        m_rdy = 1'b1;
    endtask

    // Monitor: every write the DUT presents must match the oldest expected write.
    always @(posedge clk) begin
        wr_t e;
        #1;
        if (rst && wb_ena === 1'b1) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL sb_unexpected: got write x%0d=%0h, expected none", wb_addr, wb_data);
            end else begin
                e = exp_q.pop_front();
                chk("sb_addr", 64'(wb_addr), 64'(e.rd));
                chk("sb_data", 64'(wb_data), 64'(e.data));
            end
        end
    end

    initial begin
        int last, na;
        do_reset();
        idle(2);

        // single ALU write latency
        cyc(1, 5'd5, 64'h1234, 0, 5'd0, '0);
        cyc(0, 5'd0, '0, 0, 5'd0, '0);
        chk("lat_pend5_E", 64'(pend_mask[5]), 64'd1);
        chk("lat_ena_E", 64'(wb_ena), 64'd0);
        cyc(0, 5'd0, '0, 0, 5'd0, '0);
        chk("lat_ena_E1", 64'(wb_ena), 64'd1);
        chk("lat_addr_E1", 64'(wb_addr), 64'd5);
        chk("lat_data_E1", 64'(wb_data), 64'h1234);
        chk("lat_pend5_E1", 64'(pend_mask[5]), 64'd1);
        cyc(0, 5'd0, '0, 0, 5'd0, '0);
        chk("lat_ena_E2", 64'(wb_ena), 64'd0);
        chk("lat_pend5_E2", 64'(pend_mask[5]), 64'd0);

        // x0 is swallowed, then a normal write follows
        cyc(1, 5'd0, 64'hdead, 0, 5'd0, '0);
        cyc(0, 5'd0, '0, 0, 5'd0, '0);
        chk("x0_ready", 64'(alu_ready), 64'd1);
        chk("x0_pend", 64'(pend_mask), 64'd0);
        cyc(0, 5'd0, '0, 0, 5'd0, '0);
        chk("x0_no_write", 64'(wb_ena), 64'd0);
        cyc(1, 5'd7, 64'h77, 0, 5'd0, '0);
        cyc(0, 5'd0, '0, 0, 5'd0, '0);
        cyc(0, 5'd0, '0, 0, 5'd0, '0);
        chk("x7_ena", 64'(wb_ena), 64'd1);
        chk("x7_addr", 64'(wb_addr), 64'd7);
        idle(2);

        // ordering within L and same-cycle push/pop
        cyc(0, 5'd0, '0, 1, 5'd3, 64'h31);
        cyc(0, 5'd0, '0, 1, 5'd4, 64'h41);
        cyc(0, 5'd0, '0, 1, 5'd3, 64'h32);
        cyc(0, 5'd0, '0, 0, 5'd0, '0);
        chk("ord_addr_4", 64'(wb_addr), 64'd4);
        chk("ord_pend3_a", 64'(pend_mask[3]), 64'd1);
        chk("ord_lsu_ready", 64'(lsu_ready), 64'd1);
        cyc(0, 5'd0, '0, 0, 5'd0, '0);
        chk("ord_addr_3", 64'(wb_addr), 64'd3);
        chk("ord_data_3", 64'(wb_data), 64'h32);
        chk("ord_pend3_b", 64'(pend_mask[3]), 64'd1);
        cyc(0, 5'd0, '0, 0, 5'd0, '0);
        chk("ord_pend3_c", 64'(pend_mask[3]), 64'd0);
        idle(2);

        // contention: both requesters streaming, A must win once every 5 writes
        for (int i = 0; i < 40; i++) begin
            cyc(1, 5'($urandom_range(1, 31)), {4'hA, 60'($urandom)},
                1, 5'($urandom_range(1, 31)), {4'hB, 60'($urandom)});
            if (i > 3 && wb_ena) src_q.push_back(wb_data[63:60] == 4'hA);
        end
        last = -1;
        na = 0;
        foreach (src_q[i]) begin
            if (src_q[i]) begin
                if (last >= 0) chk("cont_l_run", 64'(i - last - 1), 64'd4);
                last = i;
                na++;
            end
        end
        chk("cont_a_seen", 64'(na >= 2), 64'd1);
        idle(10);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            cyc(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), {$urandom, $urandom},
                1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), {$urandom, $urandom});
        end

        // reset mid-stream with entries queued
        for (int i = 0; i < 4; i++) begin
            cyc(1, 5'($urandom_range(1, 31)), {$urandom, $urandom},
                1, 5'($urandom_range(1, 31)), {$urandom, $urandom});
        end
        chk("pre_rst_pend_nz", 64'(pend_mask != 32'd0), 64'd1);
        do_reset();
        idle(4);

        // more random traffic after recovery, then drain
        for (int i = 0; i < 200; i++) begin
            cyc(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), {$urandom, $urandom},
                1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), {$urandom, $urandom});
        end
        idle(12);
        chk("sb_empty", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single register-file write port (rd_w_ena/rd_w_addr/data) between two requesters.
- Requester A is the single-cycle ALU result path; requester L is the long-latency path (load unit / mul-div).
- Each requester has a small FIFO behind a valid/ready handshake. Arbitration is fixed-priority to L, with a starvation guard for A.
- Exports a pending-destination mask so the decode stage can stall on RAW and WAW hazards against unwritten results.

Parameters:
- DEPTH, 2, entries per requester FIFO (power of two, 2..8).
- MAX_WAIT, 4, consecutive lost-arbitration cycles after which A gets priority (1..15).
- XLEN, 64, data width (equals REG_BUS width).

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous active-low reset; rst==0 resets, release is synchronous to clk.
- alu_valid  in  1  A offers a result.
- alu_ready  out  1  A FIFO can accept.
- alu_rd  in  5  A destination register.
- alu_data  in  XLEN  A result.
- lsu_valid  in  1  L offers a result.
- lsu_ready  out  1  L FIFO can accept.
- lsu_rd  in  5  L destination register.
- lsu_data  in  XLEN  L result.
- wb_ena  out  1  regfile write enable (registered).
- wb_addr  out  5  regfile write address (registered).
- wb_data  out  XLEN  regfile write data (registered).
- pend_mask  out  32  bit i=1: a write to xi is queued or in the wb register.

Behaviour:
- Reset (rst==0, asynchronous):
  - Both FIFOs are emptied and the wait counter is cleared.
  - wb_ena=0, wb_addr=0, wb_data=0, pend_mask=0.
  - alu_ready and lsu_ready are 0 while rst==0, and 1 from the first edge after release.
  - Reset asserted mid-operation discards all queued results; no partial write is issued.
- Handshake:
  - A transfer occurs on an edge where valid&&ready.
  - ready = (count<DEPTH), taken from registered count only. A pop in the same cycle does not raise ready.
  - Inputs are sampled only on a transfer.
- x0: a transfer with rd==0 is accepted (it consumes the handshake) but is not enqueued, never reaches the wb port, and never sets pend_mask.
- Grant, evaluated combinationally each cycle on the FIFO heads:
  - Neither FIFO non-empty: no grant; wb_ena is 0 next cycle.
  - Only one FIFO non-empty: that FIFO is granted.
  - Both non-empty: L is granted, unless wait_cnt==MAX_WAIT, in which case A is granted.
- Grant effects: the granted head pops on the edge, and wb_ena/wb_addr/wb_data load from it. With no grant, wb_ena loads 0; wb_addr and wb_data hold.
- Latency: a transfer at edge E into an empty FIFO, with no contention, gives wb_ena=1 after edge E+1. The regfile commits at edge E+2. Throughput is one write per cycle.
- wait_cnt (4 bits):
  - Increments, saturating at MAX_WAIT, each cycle A is non-empty and not granted.
  - Clears on an A grant or when A is empty.
- Ordering:
  - FIFO order is preserved within each requester.
  - No ordering is guaranteed between A and L. Decode must not issue a writer of xi while pend_mask[i]=1.
- pend_mask (combinational from registered state):
  - OR of one-hot(rd) over all valid entries in both FIFOs, plus the wb register when wb_ena=1.
  - Bit 0 is always 0.
  - A bit clears in the cycle after the write leaves the wb register.
- Simultaneous enqueue and grant pop on the same FIFO: count is unchanged, and the new entry is at the tail.
- Pointers wrap modulo DEPTH. Count has log2(DEPTH)+1 bits, and full is count==DEPTH.

Decomposition:
- Shared defines file holds:
  - REG_BUS, REG_ADDR_BUS (4:0), ZERO_WORD.
  - REG_WENABLE/REG_WDISABLE for wb_ena.
- One sub-module, wb_fifo, instantiated twice:
  - Parameters DEPTH and XLEN.
  - Ports: push, push_rd, push_data, pop, head_valid, head_rd, head_data, full, and per-entry rd/valid for the mask.
- Arbitration, wait_cnt, the wb register and pend_mask live in the top.

Test Plan:
- Reset: drive rst=0 mid-stream with 2 entries queued in each FIFO -> wb_ena=0 and pend_mask=0 immediately; after release no stale write appears, and both ready signals are 1.
- Latency: single ALU transfer rd=5, data=0x1234 at edge E -> wb_ena=1, wb_addr=5, wb_data=0x1234 after edge E+1, and wb_ena=0 after E+2. pend_mask[5] is 1 from E until the cycle after the write.
- Contention: both FIFOs held full (DEPTH=2) with continuous valid -> L is granted for 4 consecutive cycles, then A once, and the pattern repeats. alu_ready and lsu_ready deassert exactly when count==2.
- x0: ALU transfer rd=0 -> alu_ready stays 1, no wb_ena, pend_mask stays 0. A following rd=7 transfer writes with the standard latency.
- Order: LSU sends rd=3,4,3 back-to-back -> writes appear in order 3,4,3. pend_mask[3] stays set until the second x3 write leaves the wb register.
- Same-cycle push/pop: FIFO at count=1 pushed and granted on the same edge -> count stays 1, and the next write is the newer entry.
